// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared constants and types for the systolic array output path.
//   PSUM_W : width of one partial-sum lane
//   DATA_W : width of the array's input operands
//   psum_t : one partial-sum lane
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int PSUM_W = 32;
    localparam int DATA_W = 9;

    typedef logic [PSUM_W-1:0] psum_t;

endpackage

// File: rtl/systolic_output_deskew_fifo.sv
// -----------------------------------------------------------------------------
// deskew_fifo
// Synchronous FIFO that buffers column-aligned result words.
//
// Ports
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push, i_data : write request and word
//   i_ready        : downstream accepts the head word this cycle
//   o_valid        : FIFO holds at least one word
//   o_data         : head word (zero while empty)
//   o_pop          : a word leaves the FIFO this cycle
//   o_drop         : a push arrived while full with no pop; word discarded
//
// A push while full is still accepted when a pop happens in the same cycle,
// because the head slot is freed on that same edge.
// -----------------------------------------------------------------------------
module deskew_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_pop,
    output logic             o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_acc;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = !w_empty && i_ready;
    assign w_push_acc = i_push && (!w_full || w_pop);

    // Storage carries no reset; only words behind a valid pointer are visible.
    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_pop   = w_pop;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/systolic_output_deskew.sv
// -----------------------------------------------------------------------------
// systolic_output_deskew
// Realigns the skewed partial sums leaving the bottom row of a systolic array
// into whole result words, buffers them in a FIFO and marks tile boundaries.
//
// Ports
//   in_clk, in_rst : clock, synchronous active-high reset
//   in_south       : COL lanes of 32-bit partial sums, lane c at [c*32 +: 32]
//   in_valid       : per-lane valid for in_south
//   out_data       : aligned result word at the FIFO head
//   out_valid      : FIFO head is valid
//   in_ready       : downstream accepts out_data this cycle
//   out_last       : head word is the ROW-th word of its tile
//   out_overflow   : sticky, an aligned word was dropped on a full FIFO
//   out_err        : sticky, aligned lane valids disagreed
//
// Handshake: a word transfers on a cycle where out_valid && in_ready are both
// high; while out_valid is high and in_ready low, out_data holds steady.
//
// Build option: define SYSTOLIC_DESKEW_ERRCHK_EN to include the lane-valid
// consistency check behind out_err; otherwise out_err is constant 0.
// -----------------------------------------------------------------------------
module systolic_output_deskew
    import systolic_pkg::*;
#(
    parameter int ROW   = 9,
    parameter int COL   = 3,
    parameter int DEPTH = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic [COL*PSUM_W-1:0] in_south,
    input  logic [COL-1:0]        in_valid,
    output logic [COL*PSUM_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic                  out_last,
    output logic                  out_overflow,
    output logic                  out_err
);

    localparam int WORD_W = COL * PSUM_W;
    localparam int RW     = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

    psum_t              w_dly_data [COL];
    logic [COL-1:0]     w_dly_valid;
    logic [WORD_W-1:0]  w_aligned_word;
    logic               w_aligned_valid;

    logic               w_fifo_valid;
    logic [WORD_W-1:0]  w_fifo_data;
    logic               w_fifo_pop;
    logic               w_fifo_drop;

    logic [RW-1:0]      r_row;
    logic               r_overflow;

    // Lane c enters the array's bottom row c cycles after lane 0, so it is
    // held back COL-1-c stages to line all lanes up with the last one.
    for (genvar c = 0; c < COL; c++) begin : g_col
        localparam int STAGES = COL - 1 - c;
        if (STAGES == 0) begin : g_pass
            assign w_dly_data[c]  = in_south[c*PSUM_W +: PSUM_W];
            assign w_dly_valid[c] = in_valid[c];
        end else begin : g_skew
            psum_t             r_data [STAGES];
            logic [STAGES-1:0] r_valid;

            always_ff @(posedge in_clk) begin
                if (in_rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_data[i] <= '0;
                    end
                    r_valid <= '0;
                end else begin
                    r_data[0]  <= in_south[c*PSUM_W +: PSUM_W];
                    r_valid[0] <= in_valid[c];
                    for (int i = 1; i < STAGES; i++) begin
                        r_data[i]  <= r_data[i-1];
                        r_valid[i] <= r_valid[i-1];
                    end
                end
            end

            assign w_dly_data[c]  = r_data[STAGES-1];
            assign w_dly_valid[c] = r_valid[STAGES-1];
        end
    end

    always_comb begin
        w_aligned_word = '0;
        for (int c = 0; c < COL; c++) begin
            w_aligned_word[c*PSUM_W +: PSUM_W] = w_dly_data[c];
        end
    end

    // Lane 0 is the slowest path, so its delayed valid qualifies the word.
    assign w_aligned_valid = w_dly_valid[0];

    deskew_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (in_clk),
        .i_rst   (in_rst),
        .i_push  (w_aligned_valid),
        .i_data  (w_aligned_word),
        .i_ready (in_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_pop   (w_fifo_pop),
        .o_drop  (w_fifo_drop)
    );

    // Row position of the head word within its tile.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_row <= '0;
        end else if (w_fifo_pop) begin
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held, before the edge clears state.
    assign out_valid    = w_fifo_valid && !in_rst;
    assign out_data     = in_rst ? '0 : w_fifo_data;
    assign out_last     = out_valid && (r_row == ROW_LAST);
    assign out_overflow = r_overflow;

`ifdef SYSTOLIC_DESKEW_ERRCHK_EN
    logic r_err;
    logic w_valid_mismatch;

    assign w_valid_mismatch = (w_dly_valid != '0) && (w_dly_valid != '1);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_err <= 1'b0;
        end else if (w_valid_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign out_err = r_err;
`else
    logic w_unused_valids;
    assign w_unused_valids = ^w_dly_valid;
    assign out_err         = 1'b0;
`endif

endmodule
